// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for a shared Montgomery multiplier.
// Works in the Montgomery domain and converts the result back with a final multiply-by-1.
module modexp_ctrl #(
  parameter int WIDTH   = 1024,
  parameter int EBITS_W = 11
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_r,
  input  logic [WIDTH-1:0]   in_e,
  input  logic [EBITS_W-1:0] in_ebits,
  input  logic [WIDTH-1:0]   in_m,
  output logic               mont_start,
  output logic [WIDTH-1:0]   mont_a,
  output logic [WIDTH-1:0]   mont_b,
  output logic [WIDTH-1:0]   mont_m,
  input  logic [WIDTH-1:0]   mont_result,
  input  logic               mont_done,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done
);

  typedef enum logic [3:0] {
    IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, OUT_ISSUE, OUT_WAIT, DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   x_reg, x_next;
  logic [WIDTH-1:0]   e_reg, e_next;
  logic [WIDTH-1:0]   m_reg, m_next;
  logic [EBITS_W-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic [WIDTH-1:0]   mont_a_reg, mont_a_next;
  logic [WIDTH-1:0]   mont_b_reg, mont_b_next;
  logic               mont_start_reg, mont_start_next;
  logic               first_wait_reg;
  logic               busy_reg, done_reg;
  logic [EBITS_W-1:0] ebits_cap;
  logic [WIDTH-1:0]   e_shift;
  logic               wait_over;

  assign ebits_cap = (in_ebits > EBITS_W'(WIDTH)) ? EBITS_W'(WIDTH) : in_ebits;
  assign e_shift   = e_reg >> idx_reg;
  // The first WAIT cycle may still see the previous operation's done level.
  assign wait_over = mont_done && !first_wait_reg;

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    x_next      = x_reg;
    e_next      = e_reg;
    m_next      = m_reg;
    idx_next    = idx_reg;
    result_next = result_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          x_next     = in_x;
          a_next     = in_r;
          e_next     = in_e;
          m_next     = in_m;
          idx_next   = (ebits_cap != '0) ? ebits_cap - EBITS_W'(1) : '0;
          state_next = (ebits_cap != '0) ? SQ_ISSUE : OUT_ISSUE;
        end
      end
      SQ_ISSUE:  state_next = SQ_WAIT;
      SQ_WAIT: begin
        if (wait_over) begin
          a_next     = mont_result;
          state_next = e_shift[0] ? MUL_ISSUE : NEXT;
        end
      end
      MUL_ISSUE: state_next = MUL_WAIT;
      MUL_WAIT: begin
        if (wait_over) begin
          a_next     = mont_result;
          state_next = NEXT;
        end
      end
      NEXT: begin
        if (idx_reg == '0) begin
          state_next = OUT_ISSUE;
        end else begin
          idx_next   = idx_reg - EBITS_W'(1);
          state_next = SQ_ISSUE;
        end
      end
      OUT_ISSUE: state_next = OUT_WAIT;
      OUT_WAIT: begin
        if (wait_over) begin
          result_next = mont_result;
          state_next  = DONE;
        end
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Operands are registered on the edge entering an ISSUE state so they are valid with mont_start.
  always_comb begin
    mont_a_next     = mont_a_reg;
    mont_b_next     = mont_b_reg;
    mont_start_next = 1'b0;
    unique case (state_next)
      SQ_ISSUE: begin
        mont_a_next     = a_next;
        mont_b_next     = a_next;
        mont_start_next = 1'b1;
      end
      MUL_ISSUE: begin
        mont_a_next     = a_next;
        mont_b_next     = x_next;
        mont_start_next = 1'b1;
      end
      OUT_ISSUE: begin
        mont_a_next     = a_next;
        mont_b_next     = WIDTH'(1);
        mont_start_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      x_reg          <= '0;
      e_reg          <= '0;
      m_reg          <= '0;
      idx_reg        <= '0;
      result_reg     <= '0;
      mont_a_reg     <= '0;
      mont_b_reg     <= '0;
      mont_start_reg <= 1'b0;
      first_wait_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      x_reg          <= x_next;
      e_reg          <= e_next;
      m_reg          <= m_next;
      idx_reg        <= idx_next;
      result_reg     <= result_next;
      mont_a_reg     <= mont_a_next;
      mont_b_reg     <= mont_b_next;
      mont_start_reg <= mont_start_next;
      first_wait_reg <= mont_start_reg;
      busy_reg       <= (state_next != IDLE);
      done_reg       <= (state_next == DONE);
    end
  end

  assign mont_start = mont_start_reg;
  assign mont_a     = mont_a_reg;
  assign mont_b     = mont_b_reg;
  assign mont_m     = m_reg;
  assign result     = result_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl at WIDTH=8: behavioural Montgomery multiplier with adjustable latency,
// and a reference that predicts result, pulse count and timing from plain modular arithmetic.
module tb_modexp_ctrl;
  localparam int W  = 8;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_x = '0, in_r = '0, in_e = '0, in_m = '0;
  logic [EW-1:0] in_ebits = '0;
  logic          mont_start, mont_done, busy, done;
  logic [W-1:0]  mont_a, mont_b, mont_m, result;
  logic [W-1:0]  mres = '0;

  modexp_ctrl #(.WIDTH(W), .EBITS_W(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_r(in_r), .in_e(in_e), .in_ebits(in_ebits), .in_m(in_m),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mres), .mont_done(mont_done),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // a*b*R^-1 mod m with R = 256, found by search rather than by the REDC recurrence.
  function automatic logic [W-1:0] montmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    int p;
    if (m == 0) return '0;
    p = (int'(a) * int'(b)) % int'(m);
    for (int t = 0; t < int'(m); t++)
      if ((t * 256) % int'(m) == p) return t[W-1:0];
    return '0;
  endfunction

  function automatic int modpow(input int b, input int e, input int m);
    int r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  // Behavioural multiplier: done rises cfg_d cycles after the start cycle and holds until the next start.
  int   cfg_d = 4;
  bit   tie_high = 1'b0;
  int   mcnt = 0;
  int   op_age = 0;
  logic mdone_r = 1'b0;
  logic [W-1:0] lat_a = '0, lat_b = '0;
  int   pulse_cnt = 0;

  assign mont_done = tie_high ? 1'b1 : mdone_r;

  always @(posedge clk) begin
    if (mont_start === 1'b1) begin
      lat_a     <= mont_a;
      lat_b     <= mont_b;
      mres      <= montmul(mont_a, mont_b, mont_m);
      mdone_r   <= 1'b0;
      mcnt      <= 1;
      op_age    <= 1;
      pulse_cnt <= pulse_cnt + 1;
    end else begin
      if (mcnt != 0 && mcnt < cfg_d) begin
        mcnt <= mcnt + 1;
        if (mcnt + 1 == cfg_d) mdone_r <= 1'b1;
      end
      if (op_age != 0 && op_age < (tie_high ? 2 : cfg_d)) op_age <= op_age + 1;
      else op_age <= 0;
    end
  end

  // Expectations for the transaction in flight.
  bit     chk_on = 1'b0;
  int     t0 = -1, t_done = -1;
  int     n_ops = 0, pulse_base = 0;
  logic [W-1:0] m_exp = '0, res_exp = '0;
  logic   prev_ms = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", busy, (cyc > t0) && (cyc <= t_done));
      check("done", done, cyc == t_done);
      check("mont_start_gap", prev_ms & mont_start, 0);
      if (busy) check("mont_m", mont_m, m_exp);
      if (op_age != 0) begin
        check("hold_a", mont_a, lat_a);
        check("hold_b", mont_b, lat_b);
      end
    end
    prev_ms = mont_start;
  end

  task automatic start_run(input logic [W-1:0] x, input logic [W-1:0] e, input int eb,
                           input logic [W-1:0] m, input int d, input bit tie);
    int ebe, emask, de;
    cfg_d    = d;
    tie_high = tie;
    in_x     = x;
    in_r     = W'(256 % int'(m));
    in_e     = e;
    in_ebits = EW'(eb);
    in_m     = m;
    start    = 1'b1;
    ebe      = (eb > W) ? W : eb;
    emask    = int'(e) & ((1 << ebe) - 1);
    de       = tie ? 2 : d;
    n_ops    = ebe + $countones(emask) + 1;
    res_exp  = W'(modpow(int'(montmul(x, W'(1), m)), emask, int'(m)));
    m_exp    = m;
    pulse_base = pulse_cnt;
    t0       = cyc;
    t_done   = t0 + 1 + n_ops * (de + 1) + ebe;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input bit spam, input int lit_res, input int lit_lat);
    int got = -1;
    while (cyc <= t_done + 20) begin
      if (done) begin
        got = cyc;
        break;
      end
      if (spam) start = (cyc % 3 == 0);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_cycle", got, t_done);
    check("result", result, res_exp);
    check("pulses", pulse_cnt - pulse_base, n_ops);
    if (lit_res >= 0) check("result_lit", result, lit_res);
    if (lit_lat >= 0) check("latency_lit", got - t0, lit_lat);
    $display("txn m=%0d x=%0d e=0x%02h ebits=%0d d=%0d tie=%0d spam=%0d -> result=%0d exp=%0d pulses=%0d done@+%0d",
             in_m, in_x, in_e, in_ebits, cfg_d, tie_high, spam, result, res_exp,
             pulse_cnt - pulse_base, got - t0);
    @(negedge clk);
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] e, input int eb,
                     input logic [W-1:0] m, input int d, input bit tie, input bit spam,
                     input int lit_res, input int lit_lat);
    start_run(x, e, eb, m, d, tie);
    finish_run(spam, lit_res, lit_lat);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mont_start"}, mont_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_mont_a"}, mont_a, 0);
    check({tag, "_mont_b"}, mont_b, 0);
    check({tag, "_mont_m"}, mont_m, 0);
  endtask

  initial begin
    int base, seen_busy;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;

    // Directed cases from hand arithmetic: 5^3 = 125; 5^16 = 2 (mod 239) so 5^128 = 2^8 = 17.
    run(8'd85, 8'd3,    2, 8'd239, 4, 1'b0, 1'b0, 125, 28);
    run(8'd85, 8'd3,    0, 8'd239, 4, 1'b0, 1'b0, 1,   6);
    run(8'd85, 8'h80,   8, 8'd239, 4, 1'b0, 1'b0, 17,  -1);
    run(8'd85, 8'd3,    2, 8'd239, 4, 1'b1, 1'b0, 125, 18);
    run(8'd85, 8'd3,    2, 8'd239, 4, 1'b0, 1'b1, 125, 28);
    run(8'd85, 8'h81,  12, 8'd239, 3, 1'b0, 1'b0, -1,  -1);

    // Reset pulse in the middle of MUL_WAIT (start+7 .. start+10 with D=4).
    start_run(8'd85, 8'd3, 2, 8'd239, 4, 1'b0);
    while (cyc < t0 + 8) @(negedge clk);
    chk_on = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    resetn = 1'b1;
    base = pulse_cnt;
    seen_busy = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) seen_busy++;
    end
    check("post_reset_idle", seen_busy, 0);
    check("post_reset_pulses", pulse_cnt - base, 0);
    t0 = -1;
    t_done = -1;
    chk_on = 1'b1;
    run(8'd85, 8'd3, 2, 8'd239, 4, 1'b0, 1'b0, 125, 28);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] m, x, e;
      m = W'($urandom_range(1, 127) * 2 + 1);
      x = W'($urandom_range(0, int'(m) - 1));
      e = W'($urandom_range(0, 255));
      run(x, e, $urandom_range(0, 15), m, $urandom_range(2, 5),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
